mult_seq: RTL and testbench

- Multi-cycle 64x64 unsigned multiply sequencer (radix-2 shift-add); returns the low 64 bits of the product plus flags.
- Drives one instance of the team's 64-bit add/sub unit, one accumulate per cycle, instead of a combinational multiplier.
- Sits beside the ALU in the execute stage; the pipeline stalls on in_ready/out_valid.

---
 rtl/mult_seq_pkg.sv | 13 +
 rtl/mult_seq_if.sv | 26 ++
 rtl/mult_seq_arithmetic.sv | 23 ++
 rtl/mult_seq.sv | 128 ++++++++++++
 tb/tb_mult_seq.sv | 139 +++++++++++++
 5 files changed

// File: rtl/mult_seq_pkg.sv
// Shared types and sizes for the shift-add multiply sequencer.
package mult_seq_pkg;

    localparam int DATA_W = 64;
    localparam int ITER   = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mult_seq_if.sv
// Operand request / result handshake between the execute stage and mult_seq.
interface mult_seq_if;
    import mult_seq_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] result;
    logic              of;
    logic              zero;
    logic              negative;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, result, of, zero, negative
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, result, of, zero, negative
    );

endinterface

// File: rtl/mult_seq_arithmetic.sv
// Team 64-bit add/sub unit: y = a + b (sub=0) or a - b (sub=1), carry-out and signed overflow.
module arithmetic
    import mult_seq_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] y,
    output logic         C,
    output logic         of
);

    logic [W-1:0] b_eff;

    always_comb begin
        b_eff  = b ^ {W{sub}};
        {C, y} = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, sub};
        of     = (a[W-1] == b_eff[W-1]) && (y[W-1] != a[W-1]);
    end

endmodule

// File: rtl/mult_seq.sv
// Radix-2 shift-add 64x64 unsigned multiplier: one accumulate per cycle through the shared adder,
// returning the low 64 product bits with overflow/zero/negative flags.
module mult_seq
    import mult_seq_pkg::*;
#(
    parameter int EARLY_EXIT = 1,
    parameter int CNT_W      = 7
) (
    input logic       clk,
    input logic       reset,
    mult_seq_if.slave bus
);

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] acc_next;
    logic [DATA_W-1:0] mplier_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              lost;
    logic              ovf;
    logic              ovf_next;
    logic              carry;
    logic              accept;
    logic              last_iter;
    logic              unused_add_of;
    logic [DATA_W-1:0] result_r;
    logic              of_r;
    logic              zero_r;
    logic              negative_r;

    arithmetic #(.W(DATA_W)) u_add (
        .a   (acc),
        .b   (mcand),
        .sub (1'b0),
        .y   (sum),
        .C   (carry),
        .of  (unused_add_of)
    );

    // Overflow: a carry out of the accumulator, or adding a multiplicand whose
    // shifted-out bits were nonzero (its true weight is already >= 2^64).
    always_comb begin
        acc_next    = mplier[0] ? sum : acc;
        ovf_next    = ovf | (mplier[0] & (carry | lost));
        mplier_next = mplier >> 1;
        cnt_next    = cnt + CNT_W'(1);
        last_iter   = (cnt_next == CNT_W'(ITER)) ||
                      ((EARLY_EXIT != 0) && (mplier_next == '0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        accept       = 1'b0;
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    accept     = 1'b1;
                    state_next = ((EARLY_EXIT != 0) && (bus.B == '0)) ? DONE : BUSY;
                end
            end
            BUSY:    if (last_iter) state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand      <= '0;
            mplier     <= '0;
            acc        <= '0;
            cnt        <= '0;
            lost       <= 1'b0;
            ovf        <= 1'b0;
            result_r   <= '0;
            of_r       <= 1'b0;
            zero_r     <= 1'b0;
            negative_r <= 1'b0;
        end else if (accept) begin
            mcand  <= bus.A;
            mplier <= bus.B;
            acc    <= '0;
            cnt    <= '0;
            lost   <= 1'b0;
            ovf    <= 1'b0;
            if ((EARLY_EXIT != 0) && (bus.B == '0)) begin
                result_r   <= '0;
                of_r       <= 1'b0;
                zero_r     <= 1'b1;
                negative_r <= 1'b0;
            end
        end else if (state == BUSY) begin
            acc    <= acc_next;
            ovf    <= ovf_next;
            lost   <= lost | mcand[DATA_W-1];
            mcand  <= mcand << 1;
            mplier <= mplier_next;
            cnt    <= cnt_next;
            if (last_iter) begin
                result_r   <= acc_next;
                of_r       <= ovf_next;
                zero_r     <= (acc_next == '0);
                negative_r <= acc_next[DATA_W-1];
            end
        end
    end

    assign bus.result   = result_r;
    assign bus.of       = of_r;
    assign bus.zero     = zero_r;
    assign bus.negative = negative_r;

endmodule

// File: tb/tb_mult_seq.sv
// Directed and randomized checks of mult_seq, run in lockstep with EARLY_EXIT=1 and EARLY_EXIT=0.
module tb_mult_seq;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    mult_seq_if bus1();
    mult_seq_if bus0();

    mult_seq #(.EARLY_EXIT(1), .CNT_W(7)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    mult_seq #(.EARLY_EXIT(0), .CNT_W(7)) dut0 (.clk(clk), .reset(reset), .bus(bus0));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] a, input logic [63:0] b);
        bus1.in_valid = v; bus1.A = a; bus1.B = b;
        bus0.in_valid = v; bus0.A = a; bus0.B = b;
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, " in_ready1"}, bus1.in_ready, 1);
        chk({tag, " out_valid1"}, bus1.out_valid, 0);
        chk({tag, " outs1"}, {bus1.result, bus1.of, bus1.zero, bus1.negative}, 0);
        chk({tag, " in_ready0"}, bus0.in_ready, 1);
        chk({tag, " out_valid0"}, bus0.out_valid, 0);
        chk({tag, " outs0"}, {bus0.result, bus0.of, bus0.zero, bus0.negative}, 0);
    endtask

    // Issue one request to both sequencers, measure latency, check results, stall, then release.
    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp_res, input logic exp_of, input logic exp_zero,
                          input logic exp_neg, input int lat1, input int lat0, input int stall);
        int c1 = 0;
        int c0 = 0;
        int bad = 0;
        @(negedge clk);
        chk({tag, " ready"}, {bus1.in_ready, bus0.in_ready}, 2'b11);
        drive(1'b1, a, b);
        @(posedge clk); #1;
        drive(1'b0, ~a, ~b);
        for (int cyc = 1; cyc < 200 && (c1 == 0 || c0 == 0); cyc++) begin
            if (c1 == 0 && bus1.out_valid) c1 = cyc;
            if (c0 == 0 && bus0.out_valid) c0 = cyc;
            if (c1 == 0 || c0 == 0) begin
                @(posedge clk); #1;
            end
        end
        chk({tag, " lat1"}, c1, lat1);
        chk({tag, " lat0"}, c0, lat0);
        chk({tag, " res1"}, {bus1.result, bus1.of, bus1.zero, bus1.negative},
            {exp_res, exp_of, exp_zero, exp_neg});
        chk({tag, " res0"}, {bus0.result, bus0.of, bus0.zero, bus0.negative},
            {exp_res, exp_of, exp_zero, exp_neg});
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            drive(1'b1, {$urandom, $urandom}, {$urandom, $urandom});
            @(posedge clk); #1;
            if (bus1.in_ready || bus0.in_ready || !bus1.out_valid || !bus0.out_valid) bad++;
            if ({bus1.result, bus1.of, bus1.zero, bus1.negative} !== {exp_res, exp_of, exp_zero, exp_neg}) bad++;
            if ({bus0.result, bus0.of, bus0.zero, bus0.negative} !== {exp_res, exp_of, exp_zero, exp_neg}) bad++;
        end
        if (stall > 0) chk({tag, " hold"}, bad, 0);
        @(negedge clk);
        drive(1'b0, '0, '0);
        bus1.out_ready = 1'b1; bus0.out_ready = 1'b1;
        @(posedge clk); #1;
        bus1.out_ready = 1'b0; bus0.out_ready = 1'b0;
        chk({tag, " release"}, {bus1.in_ready, bus0.in_ready, bus1.out_valid, bus0.out_valid}, 4'b1100);
    endtask

    initial begin
        logic [127:0] p;
        logic [63:0]  ra;
        logic [63:0]  rb;
        int           rl1;
        int           seen = 0;

        reset = 1'b1;
        drive(1'b0, '0, '0);
        bus1.out_ready = 1'b0; bus0.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        run_op("3x5", 64'd3, 64'd5, 64'd15, 1'b0, 1'b0, 1'b0, 4, 65, 0);
        run_op("b_zero", 64'h1234, 64'd0, 64'd0, 1'b0, 1'b1, 1'b0, 1, 65, 0);
        run_op("2^32sq", 64'h1_0000_0000, 64'h1_0000_0000, 64'd0, 1'b1, 1'b1, 1'b0, 34, 65, 0);
        run_op("ones_x1", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF,
               1'b0, 1'b0, 1'b1, 2, 65, 0);
        run_op("stall", 64'd6, 64'd7, 64'd42, 1'b0, 1'b0, 1'b0, 4, 65, 10);

        // Reset lands on the edge of BUSY iteration 20.
        @(negedge clk);
        drive(1'b1, 64'hDEAD_BEEF, 64'h8000_0000_0000_0003);
        @(posedge clk); #1;
        drive(1'b0, '0, '0);
        repeat (19) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk_idle_zero("mid_busy_reset");
        @(negedge clk);
        reset = 1'b0;
        repeat (80) begin
            @(posedge clk); #1;
            if (bus1.out_valid || bus0.out_valid) seen++;
        end
        chk("abandoned", seen, 0);
        run_op("7x9", 64'd7, 64'd9, 64'd63, 1'b0, 1'b0, 1'b0, 5, 65, 0);

        for (int i = 0; i < 300; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (i % 4 == 0) rb = rb >> $urandom_range(0, 63);
            if (i % 17 == 0) rb = '0;
            p = {64'd0, ra} * {64'd0, rb};
            rl1 = 1;
            for (int k = 0; k < 64; k++) if (rb[k]) rl1 = k + 2;
            run_op("rand", ra, rb, p[63:0], |p[127:64], p[63:0] == '0, p[63],
                   rl1, 65, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
